divider_arbiter: RTL
====================

// Module: divider_arbiter
// PURPOSE
//  Shares one divider instance (8-bit dividend / 7-bit divisor, start-pulse launched,
//  fixed latency) between NREQ requesters. Round-robin arbitration, operand capture,
//  start sequencing, fixed-latency result capture, tagged response. Sits between the
//  client blocks and the divider.
// PARAMETERS
//  NREQ         4   number of requesters (2..8)
//  DIV_LATENCY 17   rising edges from start-pulse edge until divider outputs are stable
// PORTS
//  clk             in   1        system clock, all state on rising edge
//  reset           in   1        asynchronous, active-low (0 = reset)
//  req             in   NREQ     per-requester request, level, held until gnt
//  dividendin_bus  in   8*NREQ   requester i operand at [8i+7:8i]
//  divisorin_bus   in   7*NREQ   requester i operand at [7i+6:7i]
//  gnt             out  NREQ     one-hot, combinational, operands captured at this edge
//  div_start       out  1        to divider .start, one-cycle pulse
//  div_dividendin  out  8        to divider .dividendin, held for whole operation
//  div_divisorin   out  7        to divider .divisorin, held for whole operation
//  div_quotient    in   8        from divider .quotient
//  div_remainder   in   7        from divider .remainder
//  rsp_valid       out  1        one-cycle pulse, response fields valid
//  rsp_id          out  log2(NREQ) index of requester served
//  rsp_quotient    out  8        result quotient
//  rsp_remainder   out  7        result remainder
//  rsp_err         out  1        1 = divide-by-zero, divider not used
//  busy            out  1        1 in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rr pointer=0, cycle counter=0, operand regs=0; all outputs 0.
//  FSM IDLE -> START -> RUN -> DONE -> IDLE; IDLE -> DONE on zero divisor.
//  IDLE: if |req, gnt = one-hot round-robin winner (first set bit at or above pointer,
//   wrapping). At that edge: latch operands + id, pointer = winner+1 mod NREQ.
//   If latched divisor == 0 -> DONE with rsp_err=1, quotient=8'hFF, remainder=0.
//   Otherwise -> START. gnt is 0 in every other state, and in IDLE when req == 0.
//  START: div_start=1 for exactly this cycle. Edge ending START is E0.
//  RUN: counter cleared at E0, +1 per edge; at edge E0+DIV_LATENCY+1 capture
//   div_quotient/div_remainder into rsp regs -> DONE. div_valid is not used.
//  DONE: rsp_valid=1 for one cycle, rsp_* stable; next edge -> IDLE. rsp_* hold
//   their value until the next DONE.
//  Timing (DIV_LATENCY=17): gnt in cycle T, div_start in T+1, rsp_valid in T+20;
//   earliest next gnt T+21. Zero divisor: rsp_valid in T+1.
//  div_dividendin/div_divisorin are driven from operand regs at all times; they
//   change only at a grant edge, never during START/RUN.
//  Requester changing operands or dropping req after its gnt has no effect on
//   the operation in flight. req dropped before gnt: never granted.
//  All NREQ requesting continuously: grants 0,1,..,NREQ-1,0,.. (no starvation).
//  Reset mid-operation: immediate return to reset values; in-flight result
//   discarded, no rsp_valid; the next grant issues a fresh div_start.
//  Arithmetic: no width conversion; 8-bit quotient, 7-bit remainder passed through.
// STRUCTURE
//  divider_arbiter_pkg: DIVIDEND_W=8, DIVISOR_W=7, state encoding (IDLE/START/
//   RUN/DONE, 2 bits), DIV0_QUOTIENT=8'hFF.
//  Sub-module rr_arbiter (NREQ): req + pointer -> one-hot grant and winner index.
//  Counter is 5 bits (holds DIV_LATENCY+1).
// TESTING
//  1 Single req[0], 200/7 -> gnt[0] cycle T, div_start T+1, rsp_valid T+20,
//    id=0, q=28, r=4, err=0.
//  2 req=4'b1111 held, various operands -> rsp_id order 0,1,2,3,0; every
//    q*divisor+r == dividend; gnt spacing 21 cycles.
//  3 req[2] with divisor 0, dividend 99 -> rsp_valid at T+1, err=1, q=8'hFF,
//    r=0, div_start never pulses.
//  4 Requester changes operands and drops req right after gnt -> result matches
//    operands captured at gnt; div_* inputs constant from T+1 to T+19.
//  5 reset=0 at T+10 of a run -> busy, rsp_valid, div_start go 0 immediately;
//    after release, a new req yields a correct result, pointer restarted at 0.
//  6 255/1 and 0/127 -> q=255 r=0; q=0 r=0; 500 random cases vs golden model.

Source files
------------

// File: rtl/divider_arbiter_pkg.sv
// Shared widths, state encoding and constants for the divider arbiter.
package divider_arbiter_pkg;

  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W  = 7;
  localparam int CNT_W      = 5;

  localparam logic [DIVIDEND_W-1:0] DIV0_QUOTIENT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/divider_arbiter_rr.sv
// Round-robin arbiter: first request at or above the pointer wins, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    any
);

  localparam int ID_W = $clog2(NREQ);

  // Scan from the pointer upward; the first set request is the winner.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any && req[(int'(ptr) + k) % NREQ]) begin
        any = 1'b1;
        gnt[(int'(ptr) + k) % NREQ] = 1'b1;
        idx = ID_W'((int'(ptr) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/divider_arbiter.sv
// Shares one fixed-latency divider between NREQ requesters: round-robin grant,
// operand capture, start pulse, timed result capture and tagged response.
module divider_arbiter
  import divider_arbiter_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int DIV_LATENCY = 17
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [DIVIDEND_W*NREQ-1:0] dividendin_bus,
  input  logic [DIVISOR_W*NREQ-1:0]  divisorin_bus,
  output logic [NREQ-1:0]           gnt,
  output logic                      div_start,
  output logic [DIVIDEND_W-1:0]     div_dividendin,
  output logic [DIVISOR_W-1:0]      div_divisorin,
  input  logic [DIVIDEND_W-1:0]     div_quotient,
  input  logic [DIVISOR_W-1:0]      div_remainder,
  output logic                      rsp_valid,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [DIVIDEND_W-1:0]     rsp_quotient,
  output logic [DIVISOR_W-1:0]      rsp_remainder,
  output logic                      rsp_err,
  output logic                      busy
);

  localparam int              ID_W     = $clog2(NREQ);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_LATENCY);

  state_t                  state_q, state_d;
  logic [ID_W-1:0]         ptr_q, id_q, arb_idx, ptr_next;
  logic [NREQ-1:0]         arb_gnt;
  logic                    arb_any;
  logic [DIVIDEND_W-1:0]   dd_q, sel_dd;
  logic [DIVISOR_W-1:0]    dv_q, sel_dv;
  logic [CNT_W-1:0]        cnt_q;
  logic                    grant_fire, div_zero, run_last;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign sel_dd     = dividendin_bus[int'(arb_idx)*DIVIDEND_W +: DIVIDEND_W];
  assign sel_dv     = divisorin_bus[int'(arb_idx)*DIVISOR_W +: DIVISOR_W];
  assign div_zero   = (sel_dv == '0);
  assign grant_fire = (state_q == IDLE) && arb_any;
  assign run_last   = (cnt_q == CNT_LAST);
  assign ptr_next   = (arb_idx == ID_W'(NREQ-1)) ? '0 : arb_idx + 1'b1;

  assign gnt            = (state_q == IDLE) ? arb_gnt : '0;
  assign div_start      = (state_q == START);
  assign rsp_valid      = (state_q == DONE);
  assign busy           = (state_q != IDLE);
  assign div_dividendin = dd_q;
  assign div_divisorin  = dv_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: zero divisors skip the divider and answer immediately.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_fire) state_d = div_zero ? DONE : START;
      START:   state_d = RUN;
      RUN:     if (run_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture at grant, latency counter, and response capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q         <= '0;
      id_q          <= '0;
      dd_q          <= '0;
      dv_q          <= '0;
      cnt_q         <= '0;
      rsp_id        <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_err       <= 1'b0;
    end else begin
      if (grant_fire) begin
        ptr_q <= ptr_next;
        id_q  <= arb_idx;
        dd_q  <= sel_dd;
        dv_q  <= sel_dv;
        if (div_zero) begin
          rsp_id        <= arb_idx;
          rsp_quotient  <= DIV0_QUOTIENT;
          rsp_remainder <= '0;
          rsp_err       <= 1'b1;
        end
      end
      if (state_q == START) cnt_q <= '0;
      if (state_q == RUN) begin
        cnt_q <= cnt_q + 1'b1;
        if (run_last) begin
          rsp_id        <= id_q;
          rsp_quotient  <= div_quotient;
          rsp_remainder <= div_remainder;
          rsp_err       <= 1'b0;
        end
      end
    end
  end

endmodule
